// File: rtl/pf_pkg.sv
// Shared types and helpers for the next-line prefetcher.
package pf_pkg;

  localparam int PF_ADDR_W   = 32;
  localparam int PF_OFFSET_W = 5;
  localparam int LINE_BYTES  = 1 << PF_OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PROBE,
    FETCH,
    HOLD
  } pf_state_t;

  function automatic logic [PF_ADDR_W-1:0] line_align(input logic [PF_ADDR_W-1:0] addr);
    return addr & ~PF_ADDR_W'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/next_line_prefetcher.sv
// Next-line prefetcher: fetches the line after each demand miss into a one-entry buffer.
// Define PF_PAGE_BOUNDARY_EN to also suppress prefetches that would cross a page.
module next_line_prefetcher
  import pf_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5,
  parameter int PAGE_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prefetch_start,
  input  logic [ADDR_W-1:0] demand_addr,
  input  logic              demand_pmem_busy,
  output logic [ADDR_W-1:0] pf_probe_addr,
  input  logic              pf_probe_hit,
  input  logic              pf_probe_way,
  input  logic              pf_probe_dirty,
  output logic              pf_pmem_read,
  output logic [ADDR_W-1:0] pf_pmem_address,
  output logic              pf_pmem_active,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              prefetch_ready,
  input  logic              prefetch_ack,
  output logic              pf_cache_way,
  output logic [LINE_W-1:0] pf_line,
  output logic [ADDR_W-1:0] pf_addr
);

`ifdef PF_PAGE_BOUNDARY_EN
  localparam bit PAGE_GUARD = 1'b1;
`else
  localparam bit PAGE_GUARD = 1'b0;
`endif

  pf_state_t   state;
  logic        start_q;
  logic        trigger;
  logic        page_last;
  logic        drop;
  logic        in_hold;
  logic        blocked;
  logic [ADDR_W:0] target;

  // Extra MSB catches wrap past the top of the address space.
  assign target    = {1'b0, line_align(demand_addr)} + (ADDR_W+1)'(LINE_BYTES);
  assign page_last = &demand_addr[PAGE_W-1:OFFSET_W];
  assign drop      = target[ADDR_W] | (PAGE_GUARD & page_last);
  assign trigger   = prefetch_start & ~start_q & ~drop;

  assign blocked         = pf_probe_hit | pf_probe_dirty;
  assign in_hold         = (state == HOLD);
  assign pf_probe_addr   = pf_addr;
  assign pf_pmem_address = pf_addr;
  assign pf_pmem_read    = (state == FETCH);
  assign pf_pmem_active  = (state == FETCH);
  assign prefetch_ready  = in_hold & ~blocked;
  assign pf_cache_way    = in_hold & pf_probe_way;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pf_addr <= '0;
      pf_line <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= prefetch_start;
      case (state)
        IDLE: if (trigger) begin
          pf_addr <= target[ADDR_W-1:0];
          state   <= ARM;
        end
        // Let the demand fill drain before touching the tags or the adapter.
        ARM: if (!prefetch_start && !demand_pmem_busy) state <= PROBE;
        PROBE: state <= blocked ? IDLE : FETCH;
        FETCH: if (pmem_resp) begin
          pf_line <= pmem_rdata;
          state   <= HOLD;
        end
        // A demand fill may have claimed the line or dirtied the victim meanwhile.
        HOLD: if (blocked || prefetch_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_next_line_prefetcher.sv
// Bench for next_line_prefetcher: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a transaction-level model.
module tb_next_line_prefetcher;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          prefetch_start;
  logic [AW-1:0] demand_addr;
  logic          demand_pmem_busy;
  logic [AW-1:0] pf_probe_addr;
  logic          pf_probe_hit;
  logic          pf_probe_way;
  logic          pf_probe_dirty;
  logic          pf_pmem_read;
  logic [AW-1:0] pf_pmem_address;
  logic          pf_pmem_active;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;
  logic          prefetch_ready;
  logic          prefetch_ack;
  logic          pf_cache_way;
  logic [LW-1:0] pf_line;
  logic [AW-1:0] pf_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  next_line_prefetcher dut (
    .clk(clk), .rst(rst), .prefetch_start(prefetch_start), .demand_addr(demand_addr),
    .demand_pmem_busy(demand_pmem_busy), .pf_probe_addr(pf_probe_addr),
    .pf_probe_hit(pf_probe_hit), .pf_probe_way(pf_probe_way), .pf_probe_dirty(pf_probe_dirty),
    .pf_pmem_read(pf_pmem_read), .pf_pmem_address(pf_pmem_address),
    .pf_pmem_active(pf_pmem_active), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .prefetch_ready(prefetch_ready), .prefetch_ack(prefetch_ack), .pf_cache_way(pf_cache_way),
    .pf_line(pf_line), .pf_addr(pf_addr)
  );

  // Model: one outstanding prefetch, described by the phase it is in.
  localparam int M_NONE = 0, M_WAIT_DEMAND = 1, M_LOOKUP = 2, M_READING = 3, M_HELD = 4;
  int            m_phase;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_line;
  logic          m_prev_start;

`ifdef PF_PAGE_BOUNDARY_EN
  localparam bit PAGE_EN = 1'b1;
`else
  localparam bit PAGE_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    bit fetching, holding;
    fetching = (m_phase == M_READING);
    holding  = (m_phase == M_HELD);
    check("pf_addr", LW'(pf_addr), LW'(m_addr));
    check("pf_probe_addr", LW'(pf_probe_addr), LW'(m_addr));
    check("pf_pmem_address", LW'(pf_pmem_address), LW'(m_addr));
    check("pf_pmem_read", LW'(pf_pmem_read), LW'(fetching));
    check("pf_pmem_active", LW'(pf_pmem_active), LW'(fetching));
    check("prefetch_ready", LW'(prefetch_ready), LW'(holding && !pf_probe_hit && !pf_probe_dirty));
    check("pf_cache_way", LW'(pf_cache_way), LW'(holding && pf_probe_way));
    check("pf_line", pf_line, m_line);
  endtask

  task automatic model_step();
    longint unsigned nxt;
    bit suppressed;
    if (rst) begin
      m_phase = M_NONE; m_addr = '0; m_line = '0; m_prev_start = 1'b0;
    end else begin
      nxt = longint'(demand_addr) - longint'(demand_addr % 32) + 32;
      suppressed = (nxt > 64'hFFFF_FFFF) ||
                   (PAGE_EN && (((demand_addr >> 5) & 32'h7F) == 32'h7F));
      case (m_phase)
        M_NONE:        if (prefetch_start && !m_prev_start && !suppressed) begin
                         m_addr = nxt[AW-1:0]; m_phase = M_WAIT_DEMAND;
                       end
        M_WAIT_DEMAND: if (!prefetch_start && !demand_pmem_busy) m_phase = M_LOOKUP;
        M_LOOKUP:      m_phase = (pf_probe_hit || pf_probe_dirty) ? M_NONE : M_READING;
        M_READING:     if (pmem_resp) begin m_line = pmem_rdata; m_phase = M_HELD; end
        M_HELD:        if (pf_probe_hit || pf_probe_dirty || prefetch_ack) m_phase = M_NONE;
        default:       m_phase = M_NONE;
      endcase
      m_prev_start = prefetch_start;
    end
  endtask

  // One clock: compare mid-cycle, advance the model on the edge, re-drive after it.
  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    prefetch_start = 0; demand_pmem_busy = 0; pf_probe_hit = 0; pf_probe_way = 0;
    pf_probe_dirty = 0; pmem_resp = 0; prefetch_ack = 0;
  endtask

  // Trigger with addr, release start, then sit in the lookup cycle.
  task automatic trigger_to_lookup(input logic [AW-1:0] a);
    demand_addr = a; prefetch_start = 1; tick();
    prefetch_start = 0; tick();
  endtask

  initial begin
    rst = 1; idle_inputs(); demand_addr = '0; pmem_rdata = '0;
    m_phase = M_NONE; m_addr = '0; m_line = '0; m_prev_start = 0;
    tick(); tick();
    check("reset pf_addr", LW'(pf_addr), 0);
    check("reset pf_pmem_read", LW'(pf_pmem_read), 0);
    check("reset prefetch_ready", LW'(prefetch_ready), 0);
    check("reset pf_line", pf_line, 0);
    rst = 0; tick();

    // Basic install
    demand_addr = 32'h0000_1040; prefetch_start = 1; demand_pmem_busy = 1; tick(); tick();
    check("basic target", LW'(pf_addr), LW'(32'h0000_1060));
    prefetch_start = 0; tick();
    check("basic held by busy", LW'(pf_pmem_read), 0);
    demand_pmem_busy = 0; tick();   // lookup cycle next
    tick();
    check("basic fetch read", LW'(pf_pmem_read), 1);
    check("basic fetch addr", LW'(pf_pmem_address), LW'(32'h0000_1060));
    tick();
    check("basic request held", LW'(pf_pmem_read), 1);
    pmem_resp = 1; pmem_rdata = {32{8'hAA}}; tick();
    pmem_resp = 0; pf_probe_way = 1; #1;
    check("basic ready", LW'(prefetch_ready), 1);
    check("basic line", pf_line, {32{8'hAA}});
    check("basic way", LW'(pf_cache_way), 1);
    prefetch_ack = 1; tick();
    prefetch_ack = 0; pf_probe_way = 0; tick();
    check("basic idle after ack", LW'(prefetch_ready), 0);

    // Resident line
    trigger_to_lookup(32'h0000_2000);
    pf_probe_hit = 1; tick(); pf_probe_hit = 0; tick();
    check("resident no read", LW'(pf_pmem_read), 0);

    // Dirty victim
    trigger_to_lookup(32'h0000_2400);
    pf_probe_dirty = 1; tick(); pf_probe_dirty = 0; tick();
    check("dirty no read", LW'(pf_pmem_read), 0);

    // Race into the set while holding
    trigger_to_lookup(32'h0000_3000);
    tick(); pmem_resp = 1; pmem_rdata = {8{32'h1234_5678}}; tick(); pmem_resp = 0;
    pf_probe_hit = 1; #1;
    check("race ready low", LW'(prefetch_ready), 0);
    tick(); pf_probe_hit = 0; #1;
    check("race abandoned", LW'(prefetch_ready), 0);
    tick();

    // Top-of-space wrap
    trigger_to_lookup(32'hFFFF_FFE4);
    tick();
    check("wrap no read", LW'(pf_pmem_read), 0);
    check("wrap addr kept", LW'(pf_addr), LW'(32'h0000_3020));

    // Second trigger during a fetch is ignored
    trigger_to_lookup(32'h0000_4000);
    tick();
    demand_addr = 32'h0000_5000; prefetch_start = 1; tick();
    prefetch_start = 0; #1;
    check("ignored trigger addr", LW'(pf_pmem_address), LW'(32'h0000_4020));
    pmem_resp = 1; tick(); pmem_resp = 0; prefetch_ack = 1; tick(); prefetch_ack = 0;
    tick(); tick();
    check("single request only", LW'(pf_pmem_read), 0);

    // Page boundary
    trigger_to_lookup(32'h0000_0FE0);
    tick();
    check("page read", LW'(pf_pmem_read), PAGE_EN ? 0 : 1);
    if (!PAGE_EN) check("page addr", LW'(pf_pmem_address), LW'(32'h0000_1000));
    rst = 1; tick(); rst = 0; tick();

    // Reset mid-fetch
    trigger_to_lookup(32'h0000_6000);
    tick();
    check("pre-reset read", LW'(pf_pmem_read), 1);
    rst = 1; tick(); rst = 0;
    check("reset mid-fetch read", LW'(pf_pmem_read), 0);
    pmem_resp = 1; tick(); pmem_resp = 0;
    check("late resp ignored", LW'(prefetch_ready), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) prefetch_start = ~prefetch_start;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       demand_addr = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
          1:       demand_addr = ($urandom & 32'hFFFF_F000) | 32'hFE0 | ($urandom & 32'h1F);
          default: demand_addr = $urandom;
        endcase
      end
      demand_pmem_busy = ($urandom_range(0, 2) == 0);
      pf_probe_hit     = ($urandom_range(0, 7) == 0);
      pf_probe_dirty   = ($urandom_range(0, 7) == 0);
      pf_probe_way     = $urandom_range(0, 1);
      pmem_resp        = ($urandom_range(0, 3) == 0);
      pmem_rdata       = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
      prefetch_ack     = $urandom_range(0, 1);
      rst              = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
